mem_io_responder: RTL and testbench

- Memory-side responder for the byte-serial bus driven by the CPU memory controller: address, write enable, byte in, and byte out one cycle later.
- Serves a synchronous byte RAM and a memory-mapped IO region (addr[17:16]==2'b11).
- IO region holds a TX FIFO (bytes out to the host/UART) and an RX FIFO (bytes in).
- Generates io_buffer_full back-pressure to the controller and a sim_end flag.

---
 rtl/mem_io_responder_if.sv | 27 ++
 rtl/mem_io_responder.sv | 215 +++++++++++++++++++++
 tb/tb_mem_io_responder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// Byte-serial memory bus between the CPU memory controller and the
// memory-side responder.
//   rdy            global enable; low freezes the bus side
//   mem_a          byte address
//   mem_wr         1 = write mem_din at mem_a this cycle
//   mem_din        write byte
//   mem_dout       read byte, one enabled cycle after its address
//   io_buffer_full back-pressure: TX FIFO near full
// The controller uses the master modport, the responder the slave modport.
interface mem_io_responder_if;
    logic        rdy;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        io_buffer_full;

    modport master (
        output rdy, mem_a, mem_wr, mem_din,
        input  mem_dout, io_buffer_full
    );

    modport slave (
        input  rdy, mem_a, mem_wr, mem_din,
        output mem_dout, io_buffer_full
    );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder for the byte-serial CPU bus. Serves a synchronous
// byte RAM and a memory-mapped IO region (addr[17:16] == 2'b11) holding a TX
// FIFO (bytes to the host) and an RX FIFO (bytes from the host).
//   clk, rst     clock; synchronous active-high reset
//   bus          slave side of the byte bus (rdy, mem_a, mem_wr, mem_din,
//                mem_dout, io_buffer_full)
//   tx_data      TX FIFO head; tx_valid non-empty; tx_ready consumes head
//   rx_data      incoming byte; rx_valid qualifies it; rx_ready = RX not full
//   sim_end      sticky, set by a write to 0x30004
//   tx_overflow  sticky, a TX byte was dropped on a full FIFO
// IO map: 0x30000 write = TX push, read = RX pop (once per run of reads)
//         0x30004 write = set sim_end, read = {6'b0, io_buffer_full, rx_nonempty}
module mem_io_responder #(
    parameter int RAM_AW      = 17,
    parameter int TX_LOG      = 3,
    parameter int RX_LOG      = 3,
    parameter int FULL_MARGIN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_io_responder_if.slave    bus,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 sim_end,
    output logic                 tx_overflow
);

    localparam int TX_DEPTH = 1 << TX_LOG;
    localparam int RX_DEPTH = 1 << RX_LOG;
    localparam logic [TX_LOG:0] TX_FULL = {1'b1, {TX_LOG{1'b0}}};
    localparam logic [RX_LOG:0] RX_FULL = {1'b1, {RX_LOG{1'b0}}};

    // ------------------------------------------------------------------
    // Address decode (bus side, only meaningful when rdy = 1)
    // ------------------------------------------------------------------
    logic              is_io;
    logic              io_fifo_sel;   // 0x30000
    logic              io_ctrl_sel;   // 0x30004
    logic [RAM_AW-1:0] ram_addr;

    assign is_io       = (bus.mem_a[17:16] == 2'b11);
    assign io_fifo_sel = is_io && (bus.mem_a[15:0] == 16'h0000);
    assign io_ctrl_sel = is_io && (bus.mem_a[15:0] == 16'h0004);
    assign ram_addr    = bus.mem_a[RAM_AW-1:0];

    logic bus_wr_en;
    logic bus_rd_en;
    assign bus_wr_en = bus.rdy && bus.mem_wr;
    assign bus_rd_en = bus.rdy && !bus.mem_wr;

    // ------------------------------------------------------------------
    // Storage arrays (no reset: contents survive rst)
    // ------------------------------------------------------------------
    logic [7:0] ram     [0:(1<<RAM_AW)-1];
    logic [7:0] tx_mem  [0:TX_DEPTH-1];
    logic [7:0] rx_mem  [0:RX_DEPTH-1];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [TX_LOG-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [TX_LOG-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [TX_LOG:0]   tx_cnt_q,    tx_cnt_d;
    logic [RX_LOG-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [RX_LOG-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
    logic [RX_LOG:0]   rx_cnt_q,    rx_cnt_d;
    logic              io_full_q,   io_full_d;
    logic              sim_end_q,   sim_end_d;
    logic              tx_ovf_q,    tx_ovf_d;
    // Previous enabled cycle was a read of 0x30000 (run tracking for RX pop)
    logic              prev_rx_rd_q, prev_rx_rd_d;

    // TX FIFO handshake terms
    logic tx_push_req;
    logic tx_pop;
    logic tx_full;
    logic tx_accept;
    logic tx_drop;
    logic [TX_LOG:0] tx_free_next;

    // RX FIFO handshake terms
    logic rx_rd_req;
    logic rx_run_first;
    logic rx_nonempty;
    logic rx_push;
    logic rx_pop;

    always_comb begin
        // TX: a pop on a full FIFO frees the slot before the push lands
        tx_push_req  = bus_wr_en && io_fifo_sel;
        tx_pop       = (tx_cnt_q != '0) && tx_ready;
        tx_full      = (tx_cnt_q == TX_FULL);
        tx_accept    = tx_push_req && (!tx_full || tx_pop);
        tx_drop      = tx_push_req && tx_full && !tx_pop;

        tx_wr_ptr_d  = tx_accept ? tx_wr_ptr_q + 1'b1 : tx_wr_ptr_q;
        tx_rd_ptr_d  = tx_pop    ? tx_rd_ptr_q + 1'b1 : tx_rd_ptr_q;
        tx_cnt_d     = tx_cnt_q;
        case ({tx_accept, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase

        // Flag from the next count so a multi-byte store already in flight
        // still has FULL_MARGIN slots to land in.
        tx_free_next = TX_FULL - tx_cnt_d;
        io_full_d    = (int'(tx_free_next) < FULL_MARGIN);

        // RX: only the first cycle of a held read run pops
        rx_rd_req    = bus_rd_en && io_fifo_sel;
        rx_run_first = rx_rd_req && !prev_rx_rd_q;
        rx_nonempty  = (rx_cnt_q != '0);
        rx_push      = rx_valid && (rx_cnt_q != RX_FULL);
        rx_pop       = rx_run_first && rx_nonempty;

        rx_wr_ptr_d  = rx_push ? rx_wr_ptr_q + 1'b1 : rx_wr_ptr_q;
        rx_rd_ptr_d  = rx_pop  ? rx_rd_ptr_q + 1'b1 : rx_rd_ptr_q;
        rx_cnt_d     = rx_cnt_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase

        prev_rx_rd_d = bus.rdy ? rx_rd_req : prev_rx_rd_q;
        sim_end_d    = sim_end_q || (bus_wr_en && io_ctrl_sel);
        tx_ovf_d     = tx_ovf_q || tx_drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr_q  <= '0;
            tx_rd_ptr_q  <= '0;
            tx_cnt_q     <= '0;
            rx_wr_ptr_q  <= '0;
            rx_rd_ptr_q  <= '0;
            rx_cnt_q     <= '0;
            io_full_q    <= 1'b0;
            sim_end_q    <= 1'b0;
            tx_ovf_q     <= 1'b0;
            prev_rx_rd_q <= 1'b0;
        end else begin
            tx_wr_ptr_q  <= tx_wr_ptr_d;
            tx_rd_ptr_q  <= tx_rd_ptr_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_wr_ptr_q  <= rx_wr_ptr_d;
            rx_rd_ptr_q  <= rx_rd_ptr_d;
            rx_cnt_q     <= rx_cnt_d;
            io_full_q    <= io_full_d;
            sim_end_q    <= sim_end_d;
            tx_ovf_q     <= tx_ovf_d;
            prev_rx_rd_q <= prev_rx_rd_d;
        end
    end

    // ------------------------------------------------------------------
    // Array writes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (bus_wr_en && !is_io)
            ram[ram_addr] <= bus.mem_din;
    end

    always_ff @(posedge clk) begin
        if (!rst && tx_accept)
            tx_mem[tx_wr_ptr_q] <= bus.mem_din;
    end

    always_ff @(posedge clk) begin
        if (!rst && rx_push)
            rx_mem[rx_wr_ptr_q] <= rx_data;
    end

    // ------------------------------------------------------------------
    // Read data: one-cycle registered path for both RAM and IO
    // ------------------------------------------------------------------
    logic [7:0] io_rdata;
    logic [7:0] mem_dout_q;

    always_comb begin
        io_rdata = 8'h00;
        if (io_fifo_sel)
            io_rdata = rx_nonempty ? rx_mem[rx_rd_ptr_q] : 8'h00;
        else if (io_ctrl_sel)
            io_rdata = {6'b0, io_full_q, rx_nonempty};
    end

    // The RAM read sits in the same clocked block as the array index so it
    // maps onto a synchronous-read memory. On later cycles of a held RX read
    // the byte returned on the first cycle is kept, since the head has moved.
    always_ff @(posedge clk) begin
        if (rst)
            mem_dout_q <= 8'h00;
        else if (bus_rd_en) begin
            if (!is_io)
                mem_dout_q <= ram[ram_addr];
            else if (!(io_fifo_sel && prev_rx_rd_q))
                mem_dout_q <= io_rdata;
        end
    end

    assign bus.mem_dout       = mem_dout_q;
    assign bus.io_buffer_full = io_full_q;
    assign tx_data            = tx_mem[tx_rd_ptr_q];
    assign tx_valid           = (tx_cnt_q != '0);
    assign rx_ready           = (rx_cnt_q != RX_FULL);
    assign sim_end            = sim_end_q;
    assign tx_overflow        = tx_ovf_q;

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       sim_end;
    logic       tx_overflow;

    mem_io_responder_if bus_if ();

    mem_io_responder dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if.slave),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .sim_end     (sim_end),
        .tx_overflow (tx_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are examined 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic wr, input logic [31:0] a, input logic [7:0] d);
        bus_if.rdy     = 1'b1;
        bus_if.mem_wr  = wr;
        bus_if.mem_a   = a;
        bus_if.mem_din = d;
        tick();
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [7:0]  din;
        logic        chk_en;
        logic [7:0]  exp;
        string       name;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int n;

        vecs[0]  = '{1'b1, 32'h0000_0100, 8'h44, 1'b0, 8'h00, "wr100"};
        vecs[1]  = '{1'b1, 32'h0000_0101, 8'h33, 1'b0, 8'h00, "wr101"};
        vecs[2]  = '{1'b1, 32'h0000_0102, 8'h22, 1'b0, 8'h00, "wr102"};
        vecs[3]  = '{1'b1, 32'h0000_0103, 8'h11, 1'b0, 8'h00, "wr103"};
        vecs[4]  = '{1'b0, 32'h0000_0100, 8'h00, 1'b1, 8'h44, "rd100"};
        vecs[5]  = '{1'b0, 32'h0000_0101, 8'h00, 1'b1, 8'h33, "rd101"};
        vecs[6]  = '{1'b0, 32'h0000_0102, 8'h00, 1'b1, 8'h22, "rd102"};
        vecs[7]  = '{1'b0, 32'h0000_0103, 8'h00, 1'b1, 8'h11, "rd103"};
        vecs[8]  = '{1'b0, 32'h0004_0101, 8'h00, 1'b1, 8'h33, "rd_alias_hi_bits"};
        vecs[9]  = '{1'b0, 32'h0003_0008, 8'h00, 1'b1, 8'h00, "rd_io_other"};
        vecs[10] = '{1'b0, 32'h0003_0004, 8'h00, 1'b1, 8'h00, "rd_status_idle"};
        vecs[11] = '{1'b1, 32'h0000_0180, 8'hA5, 1'b0, 8'h00, "wr180"};
        vecs[12] = '{1'b0, 32'h0000_0180, 8'h00, 1'b1, 8'hA5, "rd180"};

        rst = 1'b1;
        bus_if.rdy = 1'b0; bus_if.mem_wr = 1'b0; bus_if.mem_a = '0; bus_if.mem_din = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_dout", bus_if.mem_dout, 8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_rx_ready", rx_ready, 1'b1);
        chk("rst_io_full", bus_if.io_buffer_full, 1'b0);
        chk("rst_sim_end", sim_end, 1'b0);
        chk("rst_tx_overflow", tx_overflow, 1'b0);

        // RAM and simple IO reads from the vector table
        foreach (vecs[i]) begin
            bus(vecs[i].wr, vecs[i].a, vecs[i].din);
            if (vecs[i].chk_en) chk(vecs[i].name, bus_if.mem_dout, vecs[i].exp);
        end

        // TX drain with back-pressure
        for (int i = 0; i < 5; i++) begin
            bus(1'b1, 32'h0003_0000, 8'h41 + 8'(i));
            if (i == 3) chk("tx_full_after4", bus_if.io_buffer_full, 1'b0);
        end
        chk("tx_full_after5", bus_if.io_buffer_full, 1'b1);
        bus_if.mem_wr = 1'b0; bus_if.mem_a = '0;
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("tx_drain_valid", tx_valid, 1'b1);
            chk("tx_drain_data", tx_data, 8'h41 + 8'(i));
            tick();
            if (i == 0) chk("tx_full_falls", bus_if.io_buffer_full, 1'b0);
        end
        chk("tx_drained", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // TX overflow: ninth byte dropped
        for (int i = 0; i < 9; i++) begin
            bus(1'b1, 32'h0003_0000, 8'h60 + 8'(i));
            if (i == 7) chk("tx_ovf_before", tx_overflow, 1'b0);
        end
        chk("tx_ovf_set", tx_overflow, 1'b1);
        bus_if.mem_wr = 1'b0; bus_if.mem_a = '0;
        tx_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (tx_valid) begin
                chk("tx_ovf_data", tx_data, 8'h60 + 8'(n));
                n++;
            end
            tick();
        end
        chk("tx_ovf_count", n, 8);
        chk("tx_ovf_sticky", tx_overflow, 1'b1);
        tx_ready = 1'b0;

        // RX pops: one per run of held reads
        rx_valid = 1'b1; rx_data = 8'h5A; tick();
        rx_data = 8'h6B; tick();
        rx_valid = 1'b0;
        bus(1'b0, 32'h0003_0004, 8'h00);
        chk("status_rx_only", bus_if.mem_dout, 8'h01);
        bus(1'b0, 32'h0003_0000, 8'h00);
        chk("rx_rd1_c1", bus_if.mem_dout, 8'h5A);
        bus(1'b0, 32'h0003_0000, 8'h00);
        chk("rx_rd1_c2", bus_if.mem_dout, 8'h5A);
        bus(1'b0, 32'h0000_0000, 8'h00);
        bus(1'b0, 32'h0003_0000, 8'h00);
        chk("rx_rd2", bus_if.mem_dout, 8'h6B);
        bus(1'b0, 32'h0000_0000, 8'h00);
        bus(1'b0, 32'h0003_0000, 8'h00);
        chk("rx_rd_empty", bus_if.mem_dout, 8'h00);
        bus(1'b0, 32'h0003_0004, 8'h00);
        chk("status_empty", bus_if.mem_dout, 8'h00);

        // RX fill to full
        rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rx_data = 8'h80 + 8'(i);
            tick();
            if (i == 6) chk("rx_ready_7", rx_ready, 1'b1);
            if (i == 7) chk("rx_ready_full", rx_ready, 1'b0);
        end
        rx_valid = 1'b0;
        bus(1'b0, 32'h0003_0000, 8'h00);
        chk("rx_full_head", bus_if.mem_dout, 8'h80);
        chk("rx_ready_after_pop", rx_ready, 1'b1);

        // rdy freeze
        bus(1'b1, 32'h0000_0200, 8'h77);
        bus(1'b0, 32'h0000_0100, 8'h00);
        chk("frz_pre_dout", bus_if.mem_dout, 8'h44);
        bus_if.rdy = 1'b0; bus_if.mem_wr = 1'b1; bus_if.mem_din = 8'h99;
        bus_if.mem_a = 32'h0000_0200; tick();
        chk("frz_dout_hold1", bus_if.mem_dout, 8'h44);
        bus_if.mem_a = 32'h0003_0000; tick();
        chk("frz_no_tx_push", tx_valid, 1'b0);
        chk("frz_dout_hold2", bus_if.mem_dout, 8'h44);
        bus_if.mem_a = 32'h0003_0004; tick();
        chk("frz_no_sim_end", sim_end, 1'b0);
        bus(1'b0, 32'h0000_0200, 8'h00);
        chk("frz_ram_kept", bus_if.mem_dout, 8'h77);

        // sim_end and reset mid-operation
        bus(1'b1, 32'h0003_0004, 8'h00);
        chk("sim_end_set", sim_end, 1'b1);
        bus(1'b1, 32'h0003_0000, 8'h12);
        bus(1'b0, 32'h0000_0100, 8'h00);
        chk("sim_end_sticky", sim_end, 1'b1);
        chk("pre_rst_tx_valid", tx_valid, 1'b1);
        chk("pre_rst_dout", bus_if.mem_dout, 8'h44);
        bus_if.mem_wr = 1'b0; bus_if.mem_a = '0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_sim_end", sim_end, 1'b0);
        chk("mid_rst_tx_valid", tx_valid, 1'b0);
        chk("mid_rst_dout", bus_if.mem_dout, 8'h00);
        chk("mid_rst_rx_ready", rx_ready, 1'b1);
        chk("mid_rst_tx_ovf", tx_overflow, 1'b0);
        bus(1'b0, 32'h0000_0103, 8'h00);
        chk("ram_survives_rst", bus_if.mem_dout, 8'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
